// File: rtl/instr_issuer.sv
// instr_issuer: buffers host instructions in a FIFO and issues them one at a
// time to a processor, waiting for write-back completion (or a timeout)
// before issuing the next.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              permits IDLE->ISSUE transitions
//   load_valid/instr    host instruction offer; load_ready = !full
//   wb_done             write-back completion pulse (honoured only in WAIT)
//   err_clr             clears the sticky timeout_err flag
//   instr_out           instruction presented to the processor (held)
//   instr_valid         one-cycle issue strobe (the ISSUE cycle)
//   busy                FSM in ISSUE or WAIT
//   empty, full         queue occupancy flags
//   timeout_err         sticky: an issued instruction was abandoned
//   issue_count         count of issued instructions completed by wb_done
module instr_issuer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int TIMEOUT    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_instr,
  output logic                  load_ready,
  input  logic                  wb_done,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic                  instr_valid,
  output logic                  busy,
  output logic                  empty,
  output logic                  full,
  output logic                  timeout_err,
  output logic [15:0]           issue_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                state, next_state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         head, tail;
  logic [CW-1:0]         count;
  logic [TW-1:0]         timer;

  logic do_load, do_pop, done_hit, timeout_hit;

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign load_ready  = !full;
  assign busy        = (state != IDLE);
  assign instr_valid = (state == ISSUE);

  assign do_load     = load_valid && !full;
  // The pop happens on the edge that enters ISSUE.
  assign do_pop      = (state == IDLE) && enable && !empty;
  assign done_hit    = (state == WAIT) && wb_done;
  // A completion on the final timer cycle wins over the timeout.
  assign timeout_hit = (state == WAIT) && !wb_done && (timer == TW'(TIMEOUT - 1));

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (do_pop) next_state = ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT:    if (done_hit || timeout_hit) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Queue storage is not reset; head/tail/count define its contents.
  always_ff @(posedge clk) begin
    if (do_load) mem[tail] <= load_instr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      instr_out <= '0;
    end else begin
      if (do_load) tail <= tail + 1'b1;
      if (do_pop) begin
        head      <= head + 1'b1;
        instr_out <= mem[head];
      end
      unique case ({do_load, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer       <= '0;
      issue_count <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == ISSUE)     timer <= '0;
      else if (state == WAIT) timer <= timer + 1'b1;

      if (done_hit) issue_count <= issue_count + 1'b1;

      if (timeout_hit)  timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule

// File: doc/instr_issuer.md
INSTR_ISSUER -- requirements
Module: instr_issuer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the instruction width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the queue entries (power of two).
REQ-003 The block SHALL have parameter TIMEOUT, default 8, giving the maximum WAIT cycles before abandoning an instruction.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port enable, input, 1 bit: permits new issues.
REQ-007 The block SHALL have port load_valid, input, 1 bit: host offers an instruction.
REQ-008 The block SHALL have port load_instr, input, DATA_WIDTH bits: the offered instruction.
REQ-009 The block SHALL have port load_ready, output, 1 bit: the queue accepts a load this cycle.
REQ-010 The block SHALL have port wb_done, input, 1 bit: one-cycle pulse from the processor marking write-back completion.
REQ-011 The block SHALL have port err_clr, input, 1 bit: clears timeout_err.
REQ-012 The block SHALL have port instr_out, output, DATA_WIDTH bits: the instruction presented to the processor.
REQ-013 The block SHALL have port instr_valid, output, 1 bit: one-cycle issue strobe.
REQ-014 The block SHALL have port busy, output, 1 bit: high in ISSUE or WAIT.
REQ-015 The block SHALL have port empty, output, 1 bit: queue count equals 0.
REQ-016 The block SHALL have port full, output, 1 bit: queue count equals DEPTH.
REQ-017 The block SHALL have port timeout_err, output, 1 bit: sticky timeout flag.
REQ-018 The block SHALL have port issue_count, output, 16 bits: number of issued instructions that completed with wb_done.

Function
REQ-019 The queue SHALL be a FIFO with head and tail pointers and a count of width log2(DEPTH)+1; pointers SHALL wrap modulo DEPTH.
REQ-020 load_ready SHALL equal !full.
REQ-021 A load SHALL be accepted on a rising edge with load_valid and load_ready both high; the instruction is written at tail, tail increments and count increments.
REQ-022 A simultaneous accepted load and issue-pop SHALL leave count unchanged and move both pointers.
REQ-023 load_valid while full SHALL be ignored and SHALL leave the queue unchanged.
REQ-024 The FSM SHALL have states IDLE, ISSUE and WAIT.
REQ-025 In IDLE, the FSM SHALL go to ISSUE on the next edge when enable=1 and empty=0; otherwise it stays in IDLE.
REQ-026 On entering ISSUE, instr_out SHALL register the head entry, head SHALL increment and count SHALL decrement.
REQ-027 instr_valid SHALL be high for exactly the one ISSUE cycle.
REQ-028 instr_out SHALL hold its value until the next ISSUE.
REQ-029 ISSUE SHALL always go to WAIT on the next edge and clear the wait timer to 0.
REQ-030 In WAIT, the timer SHALL increment each cycle.
REQ-031 In WAIT, wb_done=1 SHALL return the FSM to IDLE and increment issue_count; issue_count wraps at 2^16.
REQ-032 In WAIT, when the timer equals TIMEOUT-1 with wb_done=0, the FSM SHALL set timeout_err, return to IDLE and leave issue_count unchanged.
REQ-033 In WAIT, wb_done arriving in the same cycle as timer=TIMEOUT-1 SHALL count as completion, with no error.
REQ-034 wb_done outside WAIT SHALL be ignored.
REQ-035 Deasserting enable SHALL NOT abort ISSUE or WAIT; it only blocks the IDLE->ISSUE transition.
REQ-036 Minimum load-to-issue latency SHALL be 2 cycles: load accepted at edge E0, transition to ISSUE at E1, instr_valid high in the cycle after E1.
REQ-037 Maximum issue rate SHALL be one instruction per 3 cycles (ISSUE, WAIT with wb_done, IDLE).
REQ-038 timeout_err SHALL clear on err_clr=1; a set from REQ-032 in the same cycle SHALL take priority over the clear.

Reset
REQ-039 rst_n low SHALL asynchronously force FSM to IDLE and set head, tail, count, timer and issue_count to 0, instr_out=0, instr_valid=0, timeout_err=0, busy=0, empty=1, full=0, load_ready=1.
REQ-040 Reset mid-operation SHALL discard all queued instructions; queue RAM contents need not be cleared.

Verification
REQ-041 The bench SHALL cover: load 0x00221000, enable=1, wb_done 1 cycle after the strobe -> instr_valid 2 cycles after load with instr_out=0x00221000, then issue_count=1 and empty=1.
REQ-042 The bench SHALL cover: load 16 words with enable=0 -> full=1 and load_ready=0; a 17th load is ignored; enable=1 -> 16 strobes in load order.
REQ-043 The bench SHALL cover: issue with wb_done held low -> timeout_err=1 exactly 8 cycles after ISSUE and issue_count unchanged; err_clr -> timeout_err=0.
REQ-044 The bench SHALL cover: wb_done on timer=7 -> no error and issue_count increments; wb_done pulsed in IDLE -> no change.
REQ-045 The bench SHALL cover: load while issuing with count=16 -> count goes 16->15 and the load is rejected; load and pop in the same cycle at count=5 -> count stays 5.
REQ-046 The bench SHALL cover: rst_n low during WAIT with 3 queued -> IDLE, empty=1, instr_out=0 and issue_count=0 immediately, without waiting for a clock edge.
